// File: rtl/mem_cfg_sequencer_pkg.sv
// ============================================================================
//  Module   : mem_cfg_pkg
//  Purpose  : Shared types and constants for the memory config sequencer:
//             FSM state enumeration, table entry struct, default flush
//             length and an index-width helper.
//  Optional : MEM_CFG_READBACK_EN (consumed by the sequencer, not here)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_cfg_pkg;

  localparam int CFG_ADDR_W        = 32;
  localparam int CFG_DATA_W        = 32;
  localparam int DEFAULT_FLUSH_CYC = 2;

  typedef enum logic [2:0] {
    MC_IDLE     = 3'd0,
    MC_FLUSH    = 3'd1,
    MC_WRITE    = 3'd2,
    MC_RD_ISSUE = 3'd3,
    MC_RD_CHECK = 3'd4,
    MC_RUN      = 3'd5,
    MC_ERROR    = 3'd6
  } mem_cfg_state_t;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } mem_cfg_entry_t;

  // Index width that never collapses to zero bits for a one-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_cfg_sequencer_if.sv
// ============================================================================
//  Module   : mem_cfg_sequencer_if
//  Purpose  : Bundles the table-load port, sequence control, and the memory
//             core config/flush port of the config sequencer.
//  Modports : master - the sequencer (drives config_* / flush / status)
//             slave  - harness + core side (drives table, start/stop, readback)
//  Signals  : tbl_wr_en/idx/addr/data, num_entries, start, stop,
//             read_config_data, config_addr/data/write/read, flush, run_en,
//             busy, done, error, err_idx, tbl_wr_drop
//  Optional : MEM_CFG_READBACK_EN (affects sequencer behaviour only)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_cfg_sequencer_if
  import mem_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = CFG_ADDR_W,
  parameter int DATA_W      = CFG_DATA_W
);
  localparam int IDX_W = idx_width(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic              tbl_wr_en;
  logic [IDX_W-1:0]  tbl_wr_idx;
  logic [ADDR_W-1:0] tbl_wr_addr;
  logic [DATA_W-1:0] tbl_wr_data;
  logic [CNT_W-1:0]  num_entries;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] read_config_data;
  logic [ADDR_W-1:0] config_addr;
  logic [DATA_W-1:0] config_data;
  logic              config_write;
  logic              config_read;
  logic              flush;
  logic              run_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [IDX_W-1:0]  err_idx;
  logic              tbl_wr_drop;

  modport master (
    input  tbl_wr_en, tbl_wr_idx, tbl_wr_addr, tbl_wr_data, num_entries,
           start, stop, read_config_data,
    output config_addr, config_data, config_write, config_read, flush,
           run_en, busy, done, error, err_idx, tbl_wr_drop
  );

  modport slave (
    output tbl_wr_en, tbl_wr_idx, tbl_wr_addr, tbl_wr_data, num_entries,
           start, stop, read_config_data,
    input  config_addr, config_data, config_write, config_read, flush,
           run_en, busy, done, error, err_idx, tbl_wr_drop
  );

endinterface

`default_nettype wire

// File: rtl/mem_cfg_sequencer_table.sv
// ============================================================================
//  Module   : mem_cfg_table
//  Purpose  : NUM_ENTRIES-deep (address, data) register file, one synchronous
//             write port, one combinational read port. Contents not reset.
//  Ports    : clk, i_we/i_wr_idx/i_wr_addr/i_wr_data (write),
//             i_rd_idx -> o_rd_addr/o_rd_data (read)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_cfg_table #(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 4
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [IDX_W-1:0]  i_wr_idx,
  input  wire logic [ADDR_W-1:0] i_wr_addr,
  input  wire logic [DATA_W-1:0] i_wr_data,
  input  wire logic [IDX_W-1:0]  i_rd_idx,
  output logic      [ADDR_W-1:0] o_rd_addr,
  output logic      [DATA_W-1:0] o_rd_data
);

  logic [ADDR_W+DATA_W-1:0] r_mem [NUM_ENTRIES];

  // Out-of-range indices (non power-of-two depth) are silently ignored.
  always_ff @(posedge clk) begin
    if (i_we && (32'(i_wr_idx) < NUM_ENTRIES)) begin
      r_mem[i_wr_idx] <= {i_wr_addr, i_wr_data};
    end
  end

  logic [ADDR_W+DATA_W-1:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    if (32'(i_rd_idx) < NUM_ENTRIES) begin
      w_rd_word = r_mem[i_rd_idx];
    end
  end

  assign o_rd_addr = w_rd_word[ADDR_W+DATA_W-1:DATA_W];
  assign o_rd_data = w_rd_word[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mem_cfg_sequencer.sv
// ============================================================================
//  Module   : mem_cfg_sequencer
//  Purpose  : Programs the memory core's config port from a preloaded table:
//             flush pulse, one config write per entry, optional readback
//             compare, then holds run_en until stopped or restarted.
//  Ports    : clk, reset (synchronous, active-high),
//             bus (mem_cfg_sequencer_if.master) - table load, start/stop,
//             core config/flush port and status outputs.
//  Optional : MEM_CFG_READBACK_EN - enables RD_ISSUE/RD_CHECK readback,
//             error and err_idx. Undefined: WRITE goes straight to RUN and
//             config_read/error/err_idx are tied low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_cfg_sequencer
  import mem_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = CFG_ADDR_W,
  parameter int DATA_W      = CFG_DATA_W,
  parameter int FLUSH_CYC   = DEFAULT_FLUSH_CYC
) (
  input wire logic             clk,
  input wire logic             reset,
  mem_cfg_sequencer_if.master  bus
);

  localparam int IDX_W = idx_width(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'(MC_IDLE);
  localparam logic [2:0] S_FLUSH    = 3'(MC_FLUSH);
  localparam logic [2:0] S_WRITE    = 3'(MC_WRITE);
  localparam logic [2:0] S_RD_ISSUE = 3'(MC_RD_ISSUE);
  localparam logic [2:0] S_RD_CHECK = 3'(MC_RD_CHECK);
  localparam logic [2:0] S_RUN      = 3'(MC_RUN);
  localparam logic [2:0] S_ERROR    = 3'(MC_ERROR);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_n;
  logic [FC_W-1:0]   r_fcnt;
  logic              r_done;
  logic              r_tbl_wr_drop;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;

  logic              w_busy;
  logic              w_start_ok;
  logic              w_last;
  logic              w_wr_strobe;
  logic              w_rd_strobe;
  logic [CNT_W-1:0]  w_n_clamped;
  logic [ADDR_W-1:0] w_ent_addr;
  logic [DATA_W-1:0] w_ent_data;

  assign w_busy = (r_state == S_FLUSH)    || (r_state == S_WRITE) ||
                  (r_state == S_RD_ISSUE) || (r_state == S_RD_CHECK);

  // start is honoured only from the resting states.
  assign w_start_ok = bus.start &&
                      ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));

  assign w_n_clamped = (bus.num_entries > CNT_W'(NUM_ENTRIES)) ?
                       CNT_W'(NUM_ENTRIES) : bus.num_entries;

  assign w_last = ({1'b0, r_idx} == (r_n - 1'b1));

  mem_cfg_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk       (clk),
    .i_we      (bus.tbl_wr_en && !w_busy),
    .i_wr_idx  (bus.tbl_wr_idx),
    .i_wr_addr (bus.tbl_wr_addr),
    .i_wr_data (bus.tbl_wr_data),
    .i_rd_idx  (r_idx),
    .o_rd_addr (w_ent_addr),
    .o_rd_data (w_ent_data)
  );

  assign w_wr_strobe = (r_state == S_WRITE);

`ifdef MEM_CFG_READBACK_EN
  logic             r_error;
  logic [IDX_W-1:0] r_err_idx;

  assign w_rd_strobe = (r_state == S_RD_ISSUE);
`else
  logic w_unused_rd;

  assign w_rd_strobe = 1'b0;
  assign w_unused_rd = ^bus.read_config_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_n           <= '0;
      r_fcnt        <= '0;
      r_done        <= 1'b0;
      r_tbl_wr_drop <= 1'b0;
      r_hold_addr   <= '0;
      r_hold_data   <= '0;
`ifdef MEM_CFG_READBACK_EN
      r_error       <= 1'b0;
      r_err_idx     <= '0;
`endif
    end else begin
      r_done        <= 1'b0;
      r_tbl_wr_drop <= bus.tbl_wr_en && w_busy;

      if (w_start_ok) begin
        // Restart from RUN/ERROR looks identical to a start from IDLE.
        r_state <= S_FLUSH;
        r_n     <= w_n_clamped;
        r_idx   <= '0;
        r_fcnt  <= FC_W'(FLUSH_CYC - 1);
`ifdef MEM_CFG_READBACK_EN
        r_error   <= 1'b0;
        r_err_idx <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
          end

          S_FLUSH: begin
            if (r_fcnt == '0) begin
              if (r_n != '0) begin
                r_state <= S_WRITE;
              end else begin
                r_state <= S_RUN;
                r_done  <= 1'b1;
              end
            end else begin
              r_fcnt <= r_fcnt - 1'b1;
            end
          end

          S_WRITE: begin
            r_hold_addr <= w_ent_addr;
            r_hold_data <= w_ent_data;
            if (w_last) begin
              r_idx <= '0;
`ifdef MEM_CFG_READBACK_EN
              r_state <= S_RD_ISSUE;
`else
              r_state <= S_RUN;
              r_done  <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end

`ifdef MEM_CFG_READBACK_EN
          S_RD_ISSUE: begin
            r_hold_addr <= w_ent_addr;
            r_state     <= S_RD_CHECK;
          end

          // Core readback data arrives the cycle after the read strobe.
          S_RD_CHECK: begin
            if (bus.read_config_data != w_ent_data) begin
              r_error   <= 1'b1;
              r_err_idx <= r_idx;
              r_state   <= S_ERROR;
            end else if (w_last) begin
              r_idx   <= '0;
              r_state <= S_RUN;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_RD_ISSUE;
            end
          end
`endif

          S_RUN, S_ERROR: begin
            if (bus.stop) begin
              r_state <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Address/data follow the table during a strobe and hold otherwise.
  assign bus.config_addr  = (w_wr_strobe || w_rd_strobe) ? w_ent_addr : r_hold_addr;
  assign bus.config_data  = w_wr_strobe ? w_ent_data : r_hold_data;
  assign bus.config_write = w_wr_strobe;
  assign bus.config_read  = w_rd_strobe;
  assign bus.flush        = (r_state == S_FLUSH);
  assign bus.run_en       = (r_state == S_RUN);
  assign bus.busy         = w_busy;
  assign bus.done         = r_done;
  assign bus.tbl_wr_drop  = r_tbl_wr_drop;

`ifdef MEM_CFG_READBACK_EN
  assign bus.error   = r_error;
  assign bus.err_idx = r_err_idx;
`else
  assign bus.error   = 1'b0;
  assign bus.err_idx = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_cfg_sequencer.sv
// ============================================================================
//  Module   : tb_mem_cfg_sequencer
//  Purpose  : Self-checking bench for mem_cfg_sequencer. A reference table and
//             a cycle-count model of the programming sequence produce every
//             expected value; a small core model echoes written config data.
//  Optional : MEM_CFG_READBACK_EN - selects readback expectations
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_cfg_sequencer;
  import mem_cfg_pkg::*;

  localparam int NE = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FC = DEFAULT_FLUSH_CYC;
  localparam int IW = idx_width(NE);
  localparam int CW = IW + 1;

`ifdef MEM_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_cfg_sequencer_if #(.NUM_ENTRIES(NE), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_cfg_sequencer #(
    .NUM_ENTRIES (NE),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FLUSH_CYC   (FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core model: remembers written words, returns them one cycle after a read.
  logic [31:0] core_mem [logic [31:0]];
  bit          corrupt_en   = 1'b0;
  logic [31:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (bus.config_write) core_mem[bus.config_addr] = bus.config_data;
    if (bus.config_read) begin
      if (corrupt_en && (bus.config_addr == corrupt_addr))
        bus.read_config_data <= 32'hD;
      else if (core_mem.exists(bus.config_addr))
        bus.read_config_data <= core_mem[bus.config_addr];
      else
        bus.read_config_data <= '0;
    end
  end

  mem_cfg_entry_t ref_tbl [NE];
  logic [31:0]    last_addr = '0;
  logic [31:0]    last_data = '0;
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {flush, config_write, config_read, run_en, busy, done}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 64'({bus.flush, bus.config_write, bus.config_read,
                  bus.run_en, bus.busy, bus.done}), 64'(exp));
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_idx  = IW'(idx);
    bus.tbl_wr_addr = a;
    bus.tbl_wr_data = d;
    tick();
    bus.tbl_wr_en = 1'b0;
    ref_tbl[idx].addr = a;
    ref_tbl[idx].data = d;
    chk("wr_accept_no_drop", 64'(bus.tbl_wr_drop), 64'd0);
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_ctl("stopped_idle", 6'b000000);
  endtask

  // Runs one programming sequence from a resting state and checks it cycle
  // by cycle. corrupt_i >= 0 makes the core return 0xD for that entry;
  // drop_at >= 0 attempts a table write during that write cycle.
  task automatic run_prog(input int n_req, input int corrupt_i,
                          input bit with_stop, input int drop_at);
    int n;
    n = (n_req > NE) ? NE : n_req;
    corrupt_en = RB && (corrupt_i >= 0);
    if (corrupt_i >= 0) corrupt_addr = ref_tbl[corrupt_i].addr;

    bus.num_entries = CW'(n_req);
    bus.start = 1'b1;
    bus.stop  = with_stop;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    for (int c = 0; c < FC; c++) begin
      chk_ctl("flush_cycle", 6'b100010);
      if (c == 0) chk("error_cleared", 64'(bus.error), 64'd0);
      tick();
    end

    for (int i = 0; i < n; i++) begin
      chk_ctl("write_cycle", 6'b010010);
      chk("write_addr", 64'(bus.config_addr), 64'(ref_tbl[i].addr));
      chk("write_data", 64'(bus.config_data), 64'(ref_tbl[i].data));
      last_addr = ref_tbl[i].addr;
      last_data = ref_tbl[i].data;
      if (i == drop_at) begin
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_idx  = IW'((i + 1) % NE);
        bus.tbl_wr_addr = 32'hDEAD_0000;
        bus.tbl_wr_data = 32'hBAD0_BAD0;
      end
      tick();
      if (i == drop_at) begin
        bus.tbl_wr_en = 1'b0;
        chk("busy_wr_drop", 64'(bus.tbl_wr_drop), 64'd1);
      end
    end

    if (RB) begin
      for (int i = 0; i < n; i++) begin
        chk_ctl("rd_issue", 6'b001010);
        chk("rd_addr", 64'(bus.config_addr), 64'(ref_tbl[i].addr));
        tick();
        chk_ctl("rd_check", 6'b000010);
        if (i == corrupt_i) begin
          tick();
          chk_ctl("error_state", 6'b000000);
          chk("error_flag", 64'(bus.error), 64'd1);
          chk("err_idx", 64'(bus.err_idx), 64'(i));
          corrupt_en = 1'b0;
          return;
        end
        tick();
      end
    end

    corrupt_en = 1'b0;
    chk_ctl("run_first", 6'b000101);
    chk("run_no_error", 64'(bus.error), 64'd0);
    chk("hold_addr", 64'(bus.config_addr), 64'(last_addr));
    chk("hold_data", 64'(bus.config_data), 64'(last_data));
    tick();
    chk_ctl("run_hold", 6'b000100);
  endtask

  initial begin
    logic [31:0] r;
    int          n_req, n_eff, cor, drp;

    bus.tbl_wr_en   = 1'b0;
    bus.tbl_wr_idx  = '0;
    bus.tbl_wr_addr = '0;
    bus.tbl_wr_data = '0;
    bus.num_entries = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    reset           = 1'b1;
    repeat (3) tick();

    chk_ctl("reset_ctl", 6'b000000);
    chk("reset_addr", 64'(bus.config_addr), 64'd0);
    chk("reset_data", 64'(bus.config_data), 64'd0);
    chk("reset_error", 64'(bus.error), 64'd0);
    chk("reset_err_idx", 64'(bus.err_idx), 64'd0);
    chk("reset_drop", 64'(bus.tbl_wr_drop), 64'd0);
    reset = 1'b0;
    tick();

    // Directed three-entry program.
    load(0, 32'h10, 32'hA);
    load(1, 32'h14, 32'hB);
    load(2, 32'h18, 32'hC);
    run_prog(3, -1, 1'b0, -1);
    do_stop();

    // Readback mismatch on entry 1, stop holds error, restart clears it.
    if (RB) begin
      run_prog(3, 1, 1'b0, -1);
      do_stop();
      chk("error_held_after_stop", 64'(bus.error), 64'd1);
      run_prog(3, -1, 1'b0, -1);
      do_stop();
    end

    // Empty program: flush then straight to RUN.
    run_prog(0, -1, 1'b0, -1);

    // start+stop together in RUN restarts; a table write mid-WRITE is dropped.
    chk("run_before_restart", 64'(bus.run_en), 64'd1);
    run_prog(3, -1, 1'b1, 0);
    do_stop();

    // Reset while writing idx 1.
    bus.num_entries = CW'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (FC + 1) tick();
    chk_ctl("pre_reset_write", 6'b010010);
    chk("pre_reset_addr", 64'(bus.config_addr), 64'(ref_tbl[1].addr));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_addr = '0;
    last_data = '0;
    chk_ctl("midseq_reset_ctl", 6'b000000);
    chk("midseq_reset_addr", 64'(bus.config_addr), 64'd0);
    chk("midseq_reset_data", 64'(bus.config_data), 64'd0);
    chk("midseq_reset_err", 64'(bus.error), 64'd0);
    run_prog(3, -1, 1'b0, -1);

    // Randomized programs over a fully loaded table, including clamping.
    for (int i = 0; i < NE; i++) begin
      r = $urandom;
      load(i, {r[23:0], 8'(i)}, $urandom | 32'h100);
    end
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = int'($urandom_range(0, NE - 1));
        r = $urandom;
        load(j, {r[23:0], 8'(j)}, $urandom | 32'h100);
      end
      n_req = int'($urandom_range(0, NE + 3));
      n_eff = (n_req > NE) ? NE : n_req;
      cor   = (RB && (n_eff > 0) && ($urandom_range(0, 2) == 0)) ?
              int'($urandom_range(0, n_eff - 1)) : -1;
      drp   = ((n_eff > 0) && ($urandom_range(0, 1) == 1)) ?
              int'($urandom_range(0, n_eff - 1)) : -1;
      run_prog(n_req, cor, 1'($urandom_range(0, 1)), drp);
      if ($urandom_range(0, 1) == 1) do_stop();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
